// File: rtl/miriscv_decode_pkg.sv
// miriscv_decode_pkg: decoded bundle type, select encodings and SYSTEM constants
package miriscv_decode_pkg;
  localparam logic [4:0]  OPC_SYSTEM   = 5'b11100;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [6:0]  F7_BASE      = 7'h00;
  localparam logic [6:0]  F7_ALT       = 7'h20;
  localparam logic [6:0]  F7_MDU       = 7'h01;
  localparam logic [3:0]  ALU_ADD      = 4'b0000;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_MDU} wb_src_e;

  typedef struct packed {
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_re;
    logic        rs2_re;
    logic [31:0] imm;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [3:0]  alu_op;
    logic        mdu_req;
    logic [2:0]  mdu_op;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        wb_we;
    wb_src_e     wb_src;
    logic        jal;
    logic        jalr;
    logic        branch;
    logic        fence;
    logic        load;
    logic        ecall;
    logic        ebreak;
  } decode_bundle_t;
endpackage

// File: rtl/miriscv_opcodes_pkg.sv
// miriscv_opcodes_pkg: RV32I major opcodes, instr[6:2]
package miriscv_opcodes_pkg;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OPIMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
endpackage

// File: rtl/miriscv_decode_logic.sv
// miriscv_decode_logic: combinational RV32I(M) decoder; pc is filled in by the caller
module miriscv_decode_logic
  import miriscv_opcodes_pkg::*;
  import miriscv_decode_pkg::*;
#(
  parameter int unsigned RV32M     = 1,
  parameter int unsigned SYSTEM_EN = 1
) (
  input  logic [31:0]    instr_i,
  output decode_bundle_t bundle_o
);
  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  decode_bundle_t b;
  always_comb begin
    opc = instr_i[6:2];
    f3 = instr_i[14:12];
    f7 = instr_i[31:25];
    b = '0;
    b.instr = instr_i;
    b.rs1 = instr_i[19:15];
    b.rs2 = instr_i[24:20];
    b.rd = instr_i[11:7];
    b.mdu_op = f3;
    b.mem_size = f3;
    b.alu_op = ALU_ADD;
    b.op1_sel = OP1_RS1;
    b.op2_sel = OP2_IMM;
    b.wb_src = WB_ALU;
    b.imm = {{20{instr_i[31]}}, instr_i[31:20]};
    ill = instr_i[1:0] != 2'b11;
    case (opc)
      OPC_OP: begin
        b.rs1_re = 1'b1;
        b.rs2_re = 1'b1;
        b.wb_we = 1'b1;
        b.op2_sel = OP2_RS2;
        b.alu_op = {f7[5], f3};
        b.mdu_req = f7 == F7_MDU;
        b.wb_src = (f7 == F7_MDU) ? WB_MDU : WB_ALU;
        ill = ill || !(f7 inside {F7_BASE, F7_ALT, F7_MDU})
                  || (f7 == F7_ALT && !(f3 inside {3'b000, 3'b101}))
                  || (f7 == F7_MDU && RV32M == 0);
      end
      OPC_OPIMM: begin
        b.rs1_re = 1'b1;
        b.wb_we = 1'b1;
        b.alu_op = {f3 == 3'b101 && f7[5], f3};
        ill = ill || (f3 == 3'b001 && f7 != F7_BASE)
                  || (f3 == 3'b101 && !(f7 inside {F7_BASE, F7_ALT}));
      end
      OPC_LOAD: begin
        b.rs1_re = 1'b1;
        b.wb_we = 1'b1;
        b.mem_req = 1'b1;
        b.load = 1'b1;
        b.wb_src = WB_MEM;
        ill = ill || (f3 inside {3'd3, 3'd6, 3'd7});
      end
      OPC_STORE: begin
        b.rs1_re = 1'b1;
        b.rs2_re = 1'b1;
        b.mem_req = 1'b1;
        b.mem_we = 1'b1;
        b.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        ill = ill || f3 > 3'd2;
      end
      OPC_BRANCH: begin
        b.rs1_re = 1'b1;
        b.rs2_re = 1'b1;
        b.branch = 1'b1;
        b.op2_sel = OP2_RS2;
        b.alu_op = {1'b0, f3};
        b.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        ill = ill || (f3 inside {3'd2, 3'd3});
      end
      OPC_JAL: begin
        b.jal = 1'b1;
        b.wb_we = 1'b1;
        b.op1_sel = OP1_PC;
        b.wb_src = WB_PC4;
        b.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        b.jalr = 1'b1;
        b.rs1_re = 1'b1;
        b.wb_we = 1'b1;
        b.wb_src = WB_PC4;
        ill = ill || f3 != 3'd0;
      end
      OPC_LUI, OPC_AUIPC: begin
        b.wb_we = 1'b1;
        b.op1_sel = (opc == OPC_LUI) ? OP1_ZERO : OP1_PC;
        b.imm = {instr_i[31:12], 12'h000};
      end
      OPC_MISC_MEM: begin
        b.fence = 1'b1;
        ill = ill || f3 != 3'd0;
      end
      OPC_SYSTEM: begin
        b.ecall = instr_i == INSTR_ECALL;
        b.ebreak = instr_i == INSTR_EBREAK;
        ill = ill || SYSTEM_EN == 0 || !(b.ecall || b.ebreak);
      end
      default: ill = 1'b1;
    endcase
    // an illegal word must not cause any side effect downstream
    if (ill) begin
      b.wb_we = 1'b0;
      b.mem_req = 1'b0;
      b.mem_we = 1'b0;
      b.mdu_req = 1'b0;
      b.branch = 1'b0;
      b.jal = 1'b0;
      b.jalr = 1'b0;
      b.fence = 1'b0;
      b.load = 1'b0;
      b.ecall = 1'b0;
      b.ebreak = 1'b0;
      b.rs1_re = 1'b0;
      b.rs2_re = 1'b0;
    end
    b.illegal = ill;
  end
  assign bundle_o = b;
endmodule

// File: rtl/miriscv_decode_stage.sv
// miriscv_decode_stage: instruction queue feeding a registered decode output
module miriscv_decode_stage
  import miriscv_decode_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RV32M     = 1,
  parameter int unsigned SYSTEM_EN = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     f_valid_i,
  output logic                     f_ready_o,
  input  logic [31:0]              f_instr_i,
  input  logic [31:0]              f_pc_i,
  output logic                     d_valid_o,
  input  logic                     d_ready_i,
  output decode_bundle_t           d_bundle_o,
  output logic [$clog2(DEPTH):0]   q_count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic valid_q, valid_d, push, pop;
  decode_bundle_t bundle_q, bundle_d, dec;
  miriscv_decode_logic #(.RV32M(RV32M), .SYSTEM_EN(SYSTEM_EN)) u_logic (
    .instr_i  (instr_mem[rptr_q]),
    .bundle_o (dec)
  );
  assign f_ready_o = cnt_q != (AW+1)'(DEPTH);
  assign d_valid_o = valid_q;
  assign d_bundle_o = bundle_q;
  assign q_count_o = cnt_q;
  always_comb begin
    push = f_valid_i && f_ready_o;
    pop = (cnt_q != '0) && (!valid_q || d_ready_i);
    wptr_d = flush_i ? '0 : wptr_q + AW'(push);
    rptr_d = flush_i ? '0 : rptr_q + AW'(pop);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    valid_d = !flush_i && (pop || (valid_q && !d_ready_i));
    bundle_d = bundle_q;
    if (pop && !flush_i) begin
      bundle_d = dec;
      bundle_d.pc = pc_mem[rptr_q];
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      bundle_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      bundle_q <= bundle_d;
    end
  end
  // storage is never reset; occupancy alone decides what is live
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_mem[wptr_q] <= f_instr_i;
      pc_mem[wptr_q] <= f_pc_i;
    end
  end
endmodule

// File: tb/tb_miriscv_decode_stage.sv
// tb_miriscv_decode_stage: transaction model plus directed vectors, two parameterisations
module tb_miriscv_decode_stage;
  import miriscv_decode_pkg::*;
  logic clk, rst_n, flush, f_valid, d_ready;
  logic [31:0] f_instr, f_pc;
  logic f_ready, d_valid, f_ready0, d_valid0;
  logic [2:0] cnt, cnt0;
  decode_bundle_t bun, bun0;
  int total = 0, bad = 0;
  bit armed = 0;
  logic [63:0] mq [$];
  bit mv, m_pop, m_push;
  logic [31:0] m_instr, m_pc;
  logic [31:0] words [28] = '{
    32'h002081B3, 32'h022081B3, 32'h402081B3, 32'h4020D1B3, 32'h402091B3, 32'h102081B3,
    32'h00500093, 32'h4030D093, 32'h40309093, 32'h00812283, 32'h00813283, 32'h00512223,
    32'h00513223, 32'h00208463, 32'h0020A463, 32'h000000EF, 32'h000100E7, 32'h000110E7,
    32'h123452B7, 32'h12345297, 32'h0FF0000F, 32'h0000100F, 32'h00000073, 32'h00100073,
    32'h30200073, 32'h00000000, 32'hFFFFFFFF, 32'h0000002B};

  miriscv_decode_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .f_valid_i(f_valid), .f_ready_o(f_ready),
    .f_instr_i(f_instr), .f_pc_i(f_pc), .d_valid_o(d_valid), .d_ready_i(d_ready),
    .d_bundle_o(bun), .q_count_o(cnt));
  miriscv_decode_stage #(.DEPTH(4), .RV32M(0), .SYSTEM_EN(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .f_valid_i(f_valid), .f_ready_o(f_ready0),
    .f_instr_i(f_instr), .f_pc_i(f_pc), .d_valid_o(d_valid0), .d_ready_i(d_ready),
    .d_bundle_o(bun0), .q_count_o(cnt0));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic bit exp_ill(input logic [31:0] i, input bit m, input bit s);
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:2];
    f3 = i[14:12];
    f7 = i[31:25];
    if (i[1:0] != 2'b11) return 1'b1;
    case (op)
      5'h00: return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      5'h08: return f3 > 3'd2;
      5'h18: return f3 == 3'd2 || f3 == 3'd3;
      5'h19, 5'h03: return f3 != 3'd0;
      5'h1B, 5'h0D, 5'h05: return 1'b0;
      5'h04: begin
        if (f3 == 3'd1) return f7 != 7'h00;
        if (f3 == 3'd5) return f7 != 7'h00 && f7 != 7'h20;
        return 1'b0;
      end
      5'h0C: begin
        if (f7 == 7'h00) return 1'b0;
        if (f7 == 7'h20) return f3 != 3'd0 && f3 != 3'd5;
        if (f7 == 7'h01) return !m;
        return 1'b1;
      end
      5'h1C: return !s || (i != 32'h73 && i != 32'h100073);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk_b(input string t, input decode_bundle_t b, input bit m, input bit s);
    logic [31:0] i;
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    i = m_instr;
    op = i[6:2];
    f3 = i[14:12];
    f7 = i[31:25];
    ok = !exp_ill(i, m, s);
    chk({t, "illegal"}, 32'(b.illegal), 32'(!ok));
    chk({t, "pc"}, b.pc, m_pc);
    chk({t, "instr"}, b.instr, i);
    chk({t, "rd"}, 32'(b.rd), 32'(i[11:7]));
    chk({t, "rs1"}, 32'(b.rs1), 32'(i[19:15]));
    chk({t, "rs2"}, 32'(b.rs2), 32'(i[24:20]));
    chk({t, "wb_we"}, 32'(b.wb_we), 32'(ok && op != 5'h08 && op != 5'h18 && op != 5'h03 && op != 5'h1C));
    chk({t, "mdu_req"}, 32'(b.mdu_req), 32'(ok && op == 5'h0C && f7 == 7'h01));
    chk({t, "mdu_op"}, 32'(b.mdu_op), 32'(f3));
    chk({t, "mem_req"}, 32'(b.mem_req), 32'(ok && (op == 5'h00 || op == 5'h08)));
    chk({t, "mem_we"}, 32'(b.mem_we), 32'(ok && op == 5'h08));
    chk({t, "load"}, 32'(b.load), 32'(ok && op == 5'h00));
    chk({t, "branch"}, 32'(b.branch), 32'(ok && op == 5'h18));
    chk({t, "jal"}, 32'(b.jal), 32'(ok && op == 5'h1B));
    chk({t, "jalr"}, 32'(b.jalr), 32'(ok && op == 5'h19));
    chk({t, "fence"}, 32'(b.fence), 32'(ok && op == 5'h03));
    chk({t, "ecall"}, 32'(b.ecall), 32'(ok && i == 32'h73));
    chk({t, "ebreak"}, 32'(b.ebreak), 32'(ok && i == 32'h100073));
    chk({t, "rs1_re"}, 32'(b.rs1_re), 32'(ok && (op == 5'h0C || op == 5'h04 || op == 5'h00 || op == 5'h08 || op == 5'h18 || op == 5'h19)));
    chk({t, "rs2_re"}, 32'(b.rs2_re), 32'(ok && (op == 5'h0C || op == 5'h08 || op == 5'h18)));
    if (ok && op == 5'h0C) chk({t, "alu_op"}, 32'(b.alu_op), 32'({f7[5], f3}));
    if (ok && op == 5'h04) chk({t, "alu_op"}, 32'(b.alu_op), 32'({f3 == 3'd5 && f7[5], f3}));
    if (ok && (op == 5'h00 || op == 5'h08 || op == 5'h19 || op == 5'h0D || op == 5'h05))
      chk({t, "alu_op"}, 32'(b.alu_op), 32'd0);
    if (ok && (op == 5'h00 || op == 5'h04 || op == 5'h19))
      chk({t, "imm"}, b.imm, {{20{i[31]}}, i[31:20]});
    if (ok && (op == 5'h0D || op == 5'h05)) chk({t, "imm"}, b.imm, {i[31:12], 12'h000});
    if (ok && op == 5'h00) chk({t, "wb_src"}, 32'(b.wb_src), 32'(WB_MEM));
  endtask

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      mq.delete();
      mv = 0;
      if (!rst_n) begin
        m_instr = '0;
        m_pc = '0;
      end
    end else begin
      m_pop = mq.size() != 0 && (!mv || d_ready);
      m_push = f_valid && mq.size() != 4;
      if (m_pop) begin
        {m_instr, m_pc} = mq.pop_front();
        mv = 1;
      end else if (d_ready) mv = 0;
      if (m_push) mq.push_back({f_instr, f_pc});
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("count", 32'(cnt), 32'(mq.size()));
      chk("count0", 32'(cnt0), 32'(mq.size()));
      chk("f_ready", 32'(f_ready), 32'(mq.size() != 4));
      chk("f_ready0", 32'(f_ready0), 32'(mq.size() != 4));
      chk("d_valid", 32'(d_valid), 32'(mv));
      chk("d_valid0", 32'(d_valid0), 32'(mv));
      if (mv) begin
        chk_b("m1.", bun, 1'b1, 1'b1);
        chk_b("m0.", bun0, 1'b0, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    f_valid = 1;
    f_instr = i;
    f_pc = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc;
    rst_n = 0; flush = 0; f_valid = 0; f_instr = 0; f_pc = 0; d_ready = 1;
    repeat (2) step();
    chk("rst_valid", 32'(d_valid), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_ready", 32'(f_ready), 1);
    chk("rst_bundle", 32'(|bun), 0);
    rst_n = 1;
    armed = 1;
    // add x3,x1,x2: two-cycle latency
    drive(32'h002081B3, 32'h100);
    step();
    f_valid = 0;
    chk("add_early", 32'(d_valid), 0);
    step();
    chk("add_valid", 32'(d_valid), 1);
    chk("add_rd", 32'(bun.rd), 3);
    chk("add_rs1", 32'(bun.rs1), 1);
    chk("add_rs2", 32'(bun.rs2), 2);
    chk("add_wb_we", 32'(bun.wb_we), 1);
    chk("add_illegal", 32'(bun.illegal), 0);
    chk("add_pc", bun.pc, 32'h100);
    step();
    // mul with and without M
    drive(32'h022081B3, 32'h104);
    step();
    f_valid = 0;
    step();
    chk("mul0_illegal", 32'(bun0.illegal), 1);
    chk("mul0_mdu_req", 32'(bun0.mdu_req), 0);
    chk("mul0_wb_we", 32'(bun0.wb_we), 0);
    chk("mul1_mdu_req", 32'(bun.mdu_req), 1);
    chk("mul1_mdu_op", 32'(bun.mdu_op), 0);
    chk("mul1_illegal", 32'(bun.illegal), 0);
    step();
    // SYSTEM words
    drive(32'h00000073, 32'h200);
    step();
    drive(32'h00100073, 32'h204);
    step();
    chk("ecall1", 32'(bun.ecall), 1);
    chk("ecall0_illegal", 32'(bun0.illegal), 1);
    drive(32'h30200073, 32'h208);
    step();
    chk("ebreak1", 32'(bun.ebreak), 1);
    chk("ebreak0_illegal", 32'(bun0.illegal), 1);
    f_valid = 0;
    step();
    chk("mret1_illegal", 32'(bun.illegal), 1);
    chk("mret0_illegal", 32'(bun0.illegal), 1);
    step();
    // full table under intermittent backpressure
    k = 0;
    cyc = 0;
    while (k < 28 && cyc < 500) begin
      d_ready = (cyc % 3) != 2;
      drive(words[k], 32'h1000 + 32'(4 * k));
      if (f_ready) k++;
      step();
      cyc++;
    end
    chk("stream_done", 32'(k), 28);
    f_valid = 0;
    d_ready = 1;
    repeat (8) step();
    // fill: 4 in queue + 1 in output register
    d_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h00500093, 32'h300 + 32'(4 * i));
      step();
    end
    f_valid = 0;
    chk("full_count", 32'(cnt), 4);
    chk("full_ready", 32'(f_ready), 0);
    chk("full_valid", 32'(d_valid), 1);
    chk("full_head_pc", bun.pc, 32'h300);
    d_ready = 1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("drain_valid", 32'(d_valid), 1);
      chk("drain_pc", bun.pc, 32'h300 + 32'(4 * i));
    end
    step();
    chk("drain_end", 32'(d_valid), 0);
    // flush with 3 queued and a push in the same cycle
    d_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h00812283, 32'h400 + 32'(4 * i));
      step();
    end
    chk("pre_flush_count", 32'(cnt), 3);
    chk("pre_flush_valid", 32'(d_valid), 1);
    flush = 1;
    drive(32'h002081B3, 32'h4F0);
    step();
    flush = 0;
    f_valid = 0;
    chk("flush_count", 32'(cnt), 0);
    chk("flush_valid", 32'(d_valid), 0);
    d_ready = 1;
    step();
    chk("flush_absent", 32'(d_valid), 0);
    chk("flush_count2", 32'(cnt), 0);
    // reset mid-stream with 2 queued
    d_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h00208463, 32'h500 + 32'(4 * i));
      step();
    end
    f_valid = 0;
    chk("pre_rst_count", 32'(cnt), 2);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_rst_valid", 32'(d_valid), 0);
    chk("mid_rst_count", 32'(cnt), 0);
    chk("mid_rst_ready", 32'(f_ready), 1);
    chk("mid_rst_bundle", 32'(|bun), 0);
    d_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 32'(d_valid), 0);
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/miriscv_decode_stage.md
MIRISCV_DECODE_STAGE -- requirements
Module: miriscv_decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RV32M, default 1, M-extension legal when 1.
REQ-003 SHALL have parameter SYSTEM_EN, default 1, ECALL/EBREAK legal when 1.
REQ-004 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  kill queue and output register.
REQ-007 SHALL have port f_valid_i  in  1  fetch word valid.
REQ-008 SHALL have port f_ready_o  out  1  queue can accept.
REQ-009 SHALL have port f_instr_i  in  32  fetched instruction.
REQ-010 SHALL have port f_pc_i  in  32  PC of fetched instruction.
REQ-011 SHALL have port d_valid_o  out  1  decoded bundle valid.
REQ-012 SHALL have port d_ready_i  in  1  execute stage accepts bundle.
REQ-013 SHALL have port d_bundle_o  out  decode_bundle_t  registered decoded instruction.
REQ-014 SHALL have port q_count_o  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-015 SHALL push {instr,pc} on f_valid_i && f_ready_o; f_ready_o = (q_count_o != DEPTH), no dependence on d_ready_i.
REQ-016 SHALL decode the queue head combinationally: opcode [6:2], funct3 [14:12], funct7 [31:25], rs1/rs2/rd fields, op1/op2 select, ALU op {funct7[5] for OP / shift-right OPIMM, funct3 or ADD for LOAD/STORE/JALR/LUI/AUIPC}, MDU op = funct3, mem size = funct3, WB source, jal/jalr/branch/fence/load flags.
REQ-017 SHALL flag illegal: instr[1:0] != 2'b11; unknown opcode; FENCE/JALR funct3 != 0; OP funct7 not in {0x00,0x20,0x01}; funct7 0x20 with funct3 not 000/101; funct7 0x01 with RV32M=0; bad OPIMM shift funct7; LOAD funct3 in {3,6,7}; STORE funct3 > 2; BRANCH funct3 in {2,3}.
REQ-018 SHALL decode SYSTEM (opcode 11100) as ecall (0x00000073) / ebreak (0x00100073) when SYSTEM_EN=1; any other SYSTEM encoding, or any SYSTEM when SYSTEM_EN=0, SHALL be illegal.
REQ-019 Illegal bundle SHALL carry illegal=1, pc, raw instr, and force wb_we, mem_req, mem_we, mdu_req, branch, jal, jalr, fence, load, ecall, ebreak, rs1_re, rs2_re to 0.
REQ-020 wb_we SHALL be 0 for STORE, BRANCH, FENCE, SYSTEM.
REQ-021 SHALL load output register and pop head when queue non-empty && (!d_valid_o || d_ready_i); latency push-to-d_valid_o = 2 cycles with empty queue and d_ready_i=1.
REQ-022 SHALL hold d_bundle_o stable while d_valid_o && !d_ready_i; throughput 1 instr/cycle at sustained d_ready_i=1.
REQ-023 Simultaneous push and pop SHALL keep q_count_o unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 flush_i SHALL, next edge, set q_count_o=0, pointers=0, d_valid_o=0; push and pop in the flush cycle SHALL be discarded; flush has priority over everything except reset.

Reset
REQ-025 rst_n_i low at a rising edge SHALL set d_valid_o=0, q_count_o=0, pointers=0, d_bundle_o='0, f_ready_o=1 next cycle; reset mid-stream discards all queued entries.
REQ-026 Queue storage SHALL not require reset.

Structure
REQ-027 decode_bundle_t, op-select and WB-source encodings, SYSTEM opcode and ecall/ebreak constants SHALL live in miriscv_decode_pkg; opcodes in miriscv_opcodes_pkg.
REQ-028 Combinational decode SHALL be one sub-module miriscv_decode_logic (instr in, bundle out, RV32M/SYSTEM_EN parameters); queue and output register in the top.

Verification
REQ-029 Push 0x002081B3 (add x3,x1,x2) pc 0x100, d_ready_i=1 -> d_valid_o 2 cycles later, rd=3, rs1=1, rs2=2, wb_we=1, illegal=0, pc=0x100.
REQ-030 RV32M=0, push 0x022081B3 (mul) -> illegal=1, mdu_req=0, wb_we=0; RV32M=1 same word -> mdu_req=1, mdu op=0, illegal=0.
REQ-031 DEPTH=4, d_ready_i=0, push 6 words -> f_ready_o=0 after 5 accepted (4 queue + 1 output), q_count_o=4; release d_ready_i -> all 5 exit in order, one per cycle.
REQ-032 Queue holding 3 entries, d_valid_o=1, assert flush_i with f_valid_i=1 -> next cycle q_count_o=0, d_valid_o=0, pushed word absent.
REQ-033 Push 0x00000073, 0x00100073, 0x30200073 with SYSTEM_EN=1 -> ecall=1; ebreak=1; illegal=1; SYSTEM_EN=0 -> all three illegal.
REQ-034 Assert rst_n_i low for 1 cycle mid-stream with 2 queued -> d_valid_o=0, q_count_o=0, f_ready_o=1 next cycle; no stale bundle emitted afterwards.
